// File: rtl/adc_serial_rx_pkg.sv
// Shared definitions for the ADCS7476-style serial ADC receiver.
// Holds the FSM state type, default frame geometry and the legal sample-period bound.
package adc_serial_rx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } adc_state_e;

  localparam int ADCS7476_FRAME_BITS = 16;
  localparam int ADCS7476_DATA_BITS  = 12;

  // Shortest period that fits SETUP + SHIFT + HOLD plus the commit cycle.
  function automatic int min_sample_period(input int clk_div, input int frame_bits);
    return 2 * clk_div * (frame_bits + 2) + 2;
  endfunction

endpackage

// File: rtl/adc_serial_rx_if.sv
// Sample stream from the ADC receiver to downstream sdft/waterfall logic.
// Channel c occupies sample_data[c*DATA_BITS +: DATA_BITS].
interface adc_serial_rx_if #(
  parameter int CHANNELS  = 1,
  parameter int DATA_BITS = 12
);
  logic [CHANNELS*DATA_BITS-1:0] sample_data;
  logic                          sample_valid;
  logic                          sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/adc_serial_rx_sclk_gen.sv
// Serial clock generator: CLK_DIV-cycle half periods, adc_clk idling high,
// rise/fall strobes one cycle ahead of the adc_clk edge and a count of rises.
module adc_sclk_gen #(
  parameter int CLK_DIV    = 4,
  parameter int FRAME_BITS = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            run,
  input  logic                            clk_en,
  output logic                            adc_clk,
  output logic                            half_end,
  output logic                            rise,
  output logic                            fall,
  output logic [$clog2(FRAME_BITS+1)-1:0] bit_cnt
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = $clog2(FRAME_BITS + 1);

  logic [DIV_W-1:0] div_cnt;

  assign half_end = run && (div_cnt == DIV_W'(CLK_DIV - 1));
  assign rise     = half_end && clk_en && !adc_clk;
  assign fall     = half_end && clk_en && adc_clk;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
      adc_clk <= 1'b1;
      bit_cnt <= '0;
    end else if (!run) begin
      div_cnt <= '0;
      adc_clk <= 1'b1;
      bit_cnt <= '0;
    end else begin
      div_cnt <= half_end ? '0 : div_cnt + DIV_W'(1);
      if (rise) begin
        adc_clk <= 1'b1;
        bit_cnt <= bit_cnt + BIT_W'(1);
      end else if (fall) begin
        adc_clk <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/adc_serial_rx.sv
// Master for ADCS7476-style ADCs: frames shared adc_cs/adc_clk, captures CHANNELS
// serial lines in parallel once per SAMPLE_PERIOD and offers each sample on a stream.
module adc_serial_rx
  import adc_serial_rx_pkg::*;
#(
  parameter int CHANNELS      = 1,
  parameter int FRAME_BITS    = ADCS7476_FRAME_BITS,
  parameter int DATA_BITS     = ADCS7476_DATA_BITS,
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 2000,
  parameter bit SIGNED_OUT    = 1'b0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  output logic                adc_cs,
  output logic                adc_clk,
  input  logic [CHANNELS-1:0] adc_sd,
  adc_serial_rx_if.master     smp,
  output logic                overrun,
  input  logic                overrun_clr,
  output logic                busy
);
  localparam int PER_W = $clog2(SAMPLE_PERIOD);
  localparam int BIT_W = $clog2(FRAME_BITS + 1);
  localparam int SKIP  = FRAME_BITS - DATA_BITS;

  if (CLK_DIV < 1 || DATA_BITS < 2 || DATA_BITS > FRAME_BITS ||
      SAMPLE_PERIOD < min_sample_period(CLK_DIV, FRAME_BITS)) begin : g_param_check
    $error("adc_serial_rx: illegal CLK_DIV/DATA_BITS/SAMPLE_PERIOD combination");
  end

  function automatic logic [DATA_BITS-1:0] fmt_out(input logic [DATA_BITS-1:0] raw);
    fmt_out = raw;
    if (SIGNED_OUT) fmt_out[DATA_BITS-1] = ~raw[DATA_BITS-1];
  endfunction

  adc_state_e                          state;
  logic [PER_W-1:0]                    per_cnt;
  logic                                run, clk_en, half_end, rise, fall;
  logic [BIT_W-1:0]                    bit_cnt;
  logic                                commit_p1;
  logic [CHANNELS-1:0][DATA_BITS-1:0]  shreg_p0;
  logic [CHANNELS*DATA_BITS-1:0]       result;

  assign run    = (state != ST_IDLE);
  assign clk_en = (state == ST_SETUP) ||
                  (state == ST_SHIFT && !(adc_clk && bit_cnt == BIT_W'(FRAME_BITS)));

  adc_sclk_gen #(.CLK_DIV(CLK_DIV), .FRAME_BITS(FRAME_BITS)) u_sclk (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .clk_en   (clk_en),
    .adc_clk  (adc_clk),
    .half_end (half_end),
    .rise     (rise),
    .fall     (fall),
    .bit_cnt  (bit_cnt)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      per_cnt <= '0;
    else if (!enable || per_cnt == PER_W'(SAMPLE_PERIOD - 1))
      per_cnt <= '0;
    else
      per_cnt <= per_cnt + PER_W'(1);
  end

  // Frame sequencer; commit_p1 fires the cycle after adc_cs returns high.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      adc_cs    <= 1'b1;
      busy      <= 1'b0;
      commit_p1 <= 1'b0;
    end else begin
      commit_p1 <= 1'b0;
      case (state)
        ST_IDLE: if (enable && per_cnt == '0) begin
          state  <= ST_SETUP;
          adc_cs <= 1'b0;
          busy   <= 1'b1;
        end
        ST_SETUP: if (fall) state <= ST_SHIFT;
        ST_SHIFT: if (half_end && adc_clk && bit_cnt == BIT_W'(FRAME_BITS)) state <= ST_HOLD;
        ST_HOLD: if (half_end) begin
          state     <= ST_IDLE;
          adc_cs    <= 1'b1;
          busy      <= 1'b0;
          commit_p1 <= 1'b1;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Capture on the cycle adc_clk rises; leading frame bits never reach the result.
  always_ff @(posedge clk) begin
    if (rise && bit_cnt >= BIT_W'(SKIP)) begin
      for (int c = 0; c < CHANNELS; c++)
        shreg_p0[c] <= {shreg_p0[c][DATA_BITS-2:0], adc_sd[c]};
    end
  end

  always_comb begin
    result = '0;
    for (int c = 0; c < CHANNELS; c++)
      result[c*DATA_BITS +: DATA_BITS] = fmt_out(shreg_p0[c]);
  end

  // Output stage: a pending untaken sample is never overwritten.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      smp.sample_data  <= '0;
      smp.sample_valid <= 1'b0;
      overrun          <= 1'b0;
    end else begin
      if (commit_p1 && (!smp.sample_valid || smp.sample_ready)) begin
        smp.sample_data  <= result;
        smp.sample_valid <= 1'b1;
      end else if (smp.sample_valid && smp.sample_ready) begin
        smp.sample_valid <= 1'b0;
      end
      if (commit_p1 && smp.sample_valid && !smp.sample_ready)
        overrun <= 1'b1;
      else if (overrun_clr)
        overrun <= 1'b0;
    end
  end
endmodule
